// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM (1-cycle read latency).
// Port A has fixed priority, with a starvation guard for B. Optional ARB_LOCK_EN adds lock-based ownership.
module ram_port_arbiter #(
    parameter int unsigned AW       = 13,
    parameter int unsigned DW       = 16,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          a_lock,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    input  logic          b_lock,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    owner_e     owner_q, owner_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       rd_pend_a_q, rd_pend_a_d;
    logic       rd_pend_b_q, rd_pend_b_d;

    logic       force_b;
    logic       lock_hold_a, lock_hold_b;
    logic       gnt_a, gnt_b;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            wait_cnt_q  <= '0;
            rd_pend_a_q <= 1'b0;
            rd_pend_b_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            rd_pend_a_q <= rd_pend_a_d;
            rd_pend_b_q <= rd_pend_b_d;
        end
    end

`ifdef ARB_LOCK_EN
    // Ownership only persists while the owner keeps its lock high; a low lock releases it this cycle.
    assign lock_hold_a = (owner_q == OWN_A) && a_lock;
    assign lock_hold_b = (owner_q == OWN_B) && b_lock;
`else
    logic unused_lock;
    assign unused_lock = a_lock ^ b_lock;
    assign lock_hold_a = 1'b0;
    assign lock_hold_b = 1'b0;
`endif

    assign force_b = (wait_cnt_q >= MAX_WAIT_L);

    // Grant decision and next-state
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            if (lock_hold_a) begin
                gnt_a = a_req;
            end else if (lock_hold_b) begin
                gnt_b = b_req;
            end else if (a_req && !(b_req && force_b)) begin
                gnt_a = 1'b1;
            end else if (b_req) begin
                gnt_b = 1'b1;
            end
        end

        owner_d = OWN_NONE;
`ifdef ARB_LOCK_EN
        if (gnt_a && a_lock) begin
            owner_d = OWN_A;
        end else if (gnt_b && b_lock) begin
            owner_d = OWN_B;
        end else if (lock_hold_a) begin
            owner_d = OWN_A;
        end else if (lock_hold_b) begin
            owner_d = OWN_B;
        end
`endif

        wait_cnt_d = wait_cnt_q;
        if (!b_req || gnt_b) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != 4'hF) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        rd_pend_a_d = gnt_a && !a_we;
        rd_pend_b_d = gnt_b && !b_we;
    end

    // Outputs: RAM mux and read-data return routing
    always_comb begin
        a_gnt     = gnt_a;
        b_gnt     = gnt_b;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (gnt_a) begin
            ram_addr  = a_addr;
            ram_we    = a_we;
            ram_wdata = a_wdata;
        end else if (gnt_b) begin
            ram_addr  = b_addr;
            ram_we    = b_we;
            ram_wdata = b_wdata;
        end

        a_rvalid = rd_pend_a_q && !rst;
        b_rvalid = rd_pend_b_q && !rst;
        a_rdata  = a_rvalid ? ram_rdata : '0;
        b_rdata  = b_rvalid ? ram_rdata : '0;
    end

    a_gnt_exclusive: assert property (@(posedge clk) !(a_gnt && b_gnt));
    a_gnt_needs_req: assert property (@(posedge clk) a_gnt |-> a_req);
    b_gnt_needs_req: assert property (@(posedge clk) b_gnt |-> b_req);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: vector table plus hand sequences, with a read-return scoreboard.
// Build with +define+ARB_LOCK_EN to exercise the lock-ownership sequence.
module tb_ram_port_arbiter;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst;
    logic          a_req, a_we, a_lock, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_lock, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata, ram_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] q_a [$];
    logic [DW-1:0] q_b [$];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string         name;
        logic          a_req, a_we, a_lock;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_wdata;
        logic          b_req, b_we, b_lock;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_wdata;
        logic          exp_a_gnt, exp_b_gnt;
    } vec_t;

    vec_t tbl [$];

    ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM, read returns pre-write contents
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name,
                                input logic ar, input logic aw, input logic [AW-1:0] aa,
                                input logic [DW-1:0] ad, input logic al,
                                input logic br, input logic bw, input logic [AW-1:0] ba,
                                input logic [DW-1:0] bd, input logic bl,
                                input logic ea, input logic eb);
        vec_t v;
        v.name = name;
        v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad; v.a_lock = al;
        v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd; v.b_lock = bl;
        v.exp_a_gnt = ea; v.exp_b_gnt = eb;
        return v;
    endfunction

    task automatic ret_check(input string name);
        logic [DW-1:0] d;
        chk({name, ".a_rvalid"}, 32'(a_rvalid), 32'(q_a.size() != 0));
        if (q_a.size() != 0) begin
            d = q_a.pop_front();
            if (a_rvalid) chk({name, ".a_rdata"}, 32'(a_rdata), 32'(d));
        end else begin
            chk({name, ".a_rdata0"}, 32'(a_rdata), 32'(0));
        end
        chk({name, ".b_rvalid"}, 32'(b_rvalid), 32'(q_b.size() != 0));
        if (q_b.size() != 0) begin
            d = q_b.pop_front();
            if (b_rvalid) chk({name, ".b_rdata"}, 32'(b_rdata), 32'(d));
        end else begin
            chk({name, ".b_rdata0"}, 32'(b_rdata), 32'(0));
        end
    endtask

    task automatic apply(input vec_t v);
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [DW-1:0] e_wd;
        @(negedge clk);
        a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata; a_lock = v.a_lock;
        b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata; b_lock = v.b_lock;
        #1;
        chk({v.name, ".a_gnt"}, 32'(a_gnt), 32'(v.exp_a_gnt));
        chk({v.name, ".b_gnt"}, 32'(b_gnt), 32'(v.exp_b_gnt));
        e_addr = '0; e_we = 1'b0; e_wd = '0;
        if (v.exp_a_gnt) begin
            e_addr = v.a_addr; e_we = v.a_we; e_wd = v.a_wdata;
        end else if (v.exp_b_gnt) begin
            e_addr = v.b_addr; e_we = v.b_we; e_wd = v.b_wdata;
        end
        chk({v.name, ".ram_we"}, 32'(ram_we), 32'(e_we));
        chk({v.name, ".ram_addr"}, 32'(ram_addr), 32'(e_addr));
        chk({v.name, ".ram_wdata"}, 32'(ram_wdata), 32'(e_wd));
        ret_check(v.name);
        if (v.exp_a_gnt || v.exp_b_gnt) begin
            if (e_we) ref_mem[int'(e_addr)] = e_wd;
            else if (v.exp_a_gnt) q_a.push_back(ref_mem[int'(e_addr)]);
            else q_b.push_back(ref_mem[int'(e_addr)]);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".a_gnt"}, 32'(a_gnt), 32'(0));
        chk({name, ".b_gnt"}, 32'(b_gnt), 32'(0));
        chk({name, ".a_rvalid"}, 32'(a_rvalid), 32'(0));
        chk({name, ".b_rvalid"}, 32'(b_rvalid), 32'(0));
        chk({name, ".a_rdata"}, 32'(a_rdata), 32'(0));
        chk({name, ".b_rdata"}, 32'(b_rdata), 32'(0));
        chk({name, ".ram_we"}, 32'(ram_we), 32'(0));
        chk({name, ".ram_addr"}, 32'(ram_addr), 32'(0));
        chk({name, ".ram_wdata"}, 32'(ram_wdata), 32'(0));
    endtask

    task automatic reset_cycles(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            a_req = 1'b1; a_we = 1'b1; a_addr = 13'h0AA; a_wdata = 16'hFFFF;
            b_req = 1'b1; b_we = 1'b1; b_addr = 13'h0BB; b_wdata = 16'hFFFF;
            #1;
            chk_zero(name);
        end
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        rst = 1'b0;
        a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0;
    endtask

    // Both ports requesting reads continuously: B wins every fifth cycle
    task automatic contention(input string name, input int n, input logic lk);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = mk(name, 1, 0, 13'h0001, 16'h0, lk, 1, 0, 13'h0002, 16'h0, lk,
                   (i % 5) != 4, (i % 5) == 4);
            apply(v);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_lock = 0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_lock = 0;

        reset_cycles("reset", 2);

        tbl.push_back(mk("idle",      0,0,13'h0,  16'h0,   0, 0,0,13'h0,  16'h0,   0, 0,0));
        tbl.push_back(mk("b_wr_100",  0,0,13'h0,  16'h0,   0, 1,1,13'h100,16'hBEEF,0, 0,1));
        tbl.push_back(mk("b_wr_5",    0,0,13'h0,  16'h0,   0, 1,1,13'h005,16'h1234,0, 0,1));
        tbl.push_back(mk("b_wr_1",    0,0,13'h0,  16'h0,   0, 1,1,13'h001,16'h0011,0, 0,1));
        tbl.push_back(mk("b_wr_2",    0,0,13'h0,  16'h0,   0, 1,1,13'h002,16'h0022,0, 0,1));
        tbl.push_back(mk("a_rd_5",    1,0,13'h005,16'h0,   0, 0,0,13'h0,  16'h0,   0, 1,0));
        tbl.push_back(mk("a_rd_100",  1,0,13'h100,16'h0,   0, 0,0,13'h0,  16'h0,   0, 1,0));
        tbl.push_back(mk("a_rd_1",    1,0,13'h001,16'h0,   0, 0,0,13'h0,  16'h0,   0, 1,0));
        tbl.push_back(mk("b_rd_2",    0,0,13'h0,  16'h0,   0, 1,0,13'h002,16'h0,   0, 0,1));
        tbl.push_back(mk("idle2",     0,0,13'h0,  16'h0,   0, 0,0,13'h0,  16'h0,   0, 0,0));
        tbl.push_back(mk("a_wr_3_bq", 1,1,13'h003,16'h5A5A,0, 1,0,13'h003,16'h0,   0, 1,0));
        tbl.push_back(mk("b_rd_3",    0,0,13'h0,  16'h0,   0, 1,0,13'h003,16'h0,   0, 0,1));
        tbl.push_back(mk("a_rd_b_wr", 1,0,13'h002,16'h0,   0, 1,1,13'h004,16'hC0DE,0, 1,0));
        tbl.push_back(mk("b_wr_4",    0,0,13'h0,  16'h0,   0, 1,1,13'h004,16'hC0DE,0, 0,1));
        tbl.push_back(mk("a_rd_4",    1,0,13'h004,16'h0,   0, 0,0,13'h0,  16'h0,   0, 1,0));
        tbl.push_back(mk("idle3",     0,0,13'h0,  16'h0,   0, 0,0,13'h0,  16'h0,   0, 0,0));
        foreach (tbl[i]) apply(tbl[i]);

        contention("contend", 15, 1'b0);
        apply(mk("idle4", 0,0,13'h0,16'h0,0, 0,0,13'h0,16'h0,0, 0,0));

        // Reset while an A read is in flight: no rvalid, all outputs zero
        apply(mk("pre_rst_rd", 1,0,13'h005,16'h0,0, 0,0,13'h0,16'h0,0, 1,0));
        reset_cycles("mid_rst", 2);
        contention("post_rst", 5, 1'b0);
        apply(mk("idle5", 0,0,13'h0,16'h0,0, 0,0,13'h0,16'h0,0, 0,0));

`ifdef ARB_LOCK_EN
        apply(mk("lk_a_rd", 1,0,13'h005,16'h0,1, 1,0,13'h002,16'h0,0, 1,0));
        for (int i = 0; i < 6; i++)
            apply(mk("lk_a_wr", 1,1,13'h006,16'(16'h7000 + i),1, 1,0,13'h002,16'h0,0, 1,0));
        apply(mk("lk_release", 0,0,13'h0,16'h0,0, 1,0,13'h002,16'h0,0, 0,1));
        apply(mk("lk_a_rd6", 1,0,13'h006,16'h0,0, 0,0,13'h0,16'h0,0, 1,0));
        apply(mk("idle6", 0,0,13'h0,16'h0,0, 0,0,13'h0,16'h0,0, 0,0));
`else
        contention("lock_ignored", 10, 1'b1);
        apply(mk("idle6", 0,0,13'h0,16'h0,0, 0,0,13'h0,16'h0,0, 0,0));
`endif

        chk("scoreboard_empty", 32'(q_a.size() + q_b.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port synchronous data RAM (1-cycle read latency) between two requesters.
- Port A: projectCPU2020 core, primary.
- Port B: DMA/program-loader, secondary.
- Fixed priority to A, with a starvation guard that forces a grant to B after MAX_WAIT lost cycles; routes read data back to the requester that issued the read.

Parameters:
- AW, 13, RAM address width
- DW, 16, RAM data width
- MAX_WAIT, 4, consecutive cycles B may lose arbitration before B is forced ahead of A (1..15)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- a_req  input  1  port A access request
- a_we  input  1  port A write enable (valid with a_req)
- a_addr  input  AW  port A address
- a_wdata  input  DW  port A write data
- a_lock  input  1  port A hold-ownership request (used only with ARB_LOCK_EN)
- a_gnt  output  1  port A access performed this cycle
- a_rvalid  output  1  port A read data valid
- a_rdata  output  DW  port A read data
- b_req, b_we, b_addr, b_wdata, b_lock, b_gnt, b_rvalid, b_rdata: same as port A, for port B
- ram_addr  output  AW  RAM address
- ram_we  output  1  RAM write strobe
- ram_wdata  output  DW  RAM write data
- ram_rdata  input  DW  RAM read data, valid the cycle after the address

Behaviour:
- Reset (rst high at posedge): wait_cnt=0, owner=NONE, rd_pend_a=rd_pend_b=0. All outputs forced 0 while rst is high. A read in flight at reset produces no rvalid.
- Arbitration is combinational within the cycle:
  - force_b = (wait_cnt >= MAX_WAIT).
  - Without a lock owner: a_req && !(b_req && force_b) grants A; else b_req grants B; else nothing.
- gnt is high in the same cycle the access is issued to RAM. The requester holds req/we/addr/wdata stable until it sees gnt; deasserting req before gnt is legal and simply withdraws the request.
- Granted port drives ram_addr/ram_we/ram_wdata. ram_we = granted && we. With no grant: ram_we=0, ram_addr=0, ram_wdata=0.
- Back-to-back grants are allowed every cycle: one access per cycle, no bubble.
- Read return:
  - rd_pend_x <= gnt_x && !we_x.
  - Next cycle: x_rvalid = rd_pend_x, x_rdata = ram_rdata. Otherwise x_rdata=0.
  - Latency from grant to rvalid is exactly 1 cycle.
  - A write grant produces no rvalid.
- wait_cnt (4-bit, saturating at 15):
  - Increments when b_req && !b_gnt.
  - Clears on b_gnt or when b_req is low.
- Simultaneous a_req and b_req with force_b low: A wins and wait_cnt increments.
- Once B is granted while forced, wait_cnt clears and A regains priority on the next cycle.
- Write and read to the same address in consecutive cycles by different ports: the RAM's read-after-write semantics apply; no forwarding.

Optional Feature:
- Macro: ARB_LOCK_EN.
- With ARB_LOCK_EN defined:
  - Owner register: a port that receives gnt while its lock is high becomes owner.
  - While owner's lock stays high, only the owner can be granted, even with force_b set. The other port waits and wait_cnt keeps counting, saturating at 15.
  - Ownership is released in the cycle the owner's lock is sampled low, and arbitration reverts to normal that same cycle.
  - Reset clears the owner.
  - Supports atomic read-modify-write.
- Without ARB_LOCK_EN: a_lock/b_lock are ignored; owner is always NONE.

Test Plan:
- A-only read: a_req=1, a_we=0, a_addr=0x0005, RAM[5]=0x1234 -> a_gnt=1 in cycle 0, a_rvalid=1 and a_rdata=0x1234 in cycle 1, b_rvalid=0.
- B-only write: b_req=1, b_we=1, b_addr=0x0100, b_wdata=0xBEEF -> b_gnt=1, ram_we=1, ram_addr=0x0100, ram_wdata=0xBEEF same cycle; no rvalid; readback via A returns 0xBEEF.
- Contention, MAX_WAIT=4: a_req and b_req held high continuously -> grant pattern A,A,A,A,B,A,A,A,A,B,...; wait_cnt reaches 4 then clears.
- Interleaved reads: A reads addr 1 (0x0011) in cycle 0, B reads addr 2 (0x0022) in cycle 1 -> a_rvalid/0x0011 in cycle 1, b_rvalid/0x0022 in cycle 2, no cross-routing.
- Reset mid-read: A read granted in cycle 0, rst high in cycle 1 -> a_rvalid=0 in cycle 1; all outputs 0; wait_cnt=0 after reset.
- ARB_LOCK_EN: A read with a_lock=1, B requesting, then A write with lock held for 6 cycles -> only A granted, b_gnt=0 throughout; a_lock low -> B granted in that same cycle.
